// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared pipeline types and constants for the in-order MIPS core.
//   entry_t      : one tracked in-flight destination {valid, ld, dst}
//   FWD_REGFILE  : fwd_sel value meaning "read the register file"
//   dec_t / decode_op : opcode -> {wr, ld, src1_en, src2_en} used by decode
//                       to drive the hazard scoreboard.
package pipe_pkg;

  // Widest register index supported by entry_t (up to 256 registers).
  localparam int MAX_RW      = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic              valid;
    logic              ld;
    logic [MAX_RW-1:0] dst;
  } entry_t;

  // Primary MIPS opcodes the core decodes.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic wr;
    logic ld;
    logic src1_en;
    logic src2_en;
  } dec_t;

  localparam dec_t DEC_RTYPE = '{wr: 1'b1, ld: 1'b0, src1_en: 1'b1, src2_en: 1'b1};
  localparam dec_t DEC_ADDI  = '{wr: 1'b1, ld: 1'b0, src1_en: 1'b1, src2_en: 1'b0};
  localparam dec_t DEC_LW    = '{wr: 1'b1, ld: 1'b1, src1_en: 1'b1, src2_en: 1'b0};
  localparam dec_t DEC_SW    = '{wr: 1'b0, ld: 1'b0, src1_en: 1'b1, src2_en: 1'b1};
  localparam dec_t DEC_BEQ   = '{wr: 1'b0, ld: 1'b0, src1_en: 1'b1, src2_en: 1'b1};
  localparam dec_t DEC_NONE  = '{wr: 1'b0, ld: 1'b0, src1_en: 1'b0, src2_en: 1'b0};

  function automatic dec_t decode_op(input logic [5:0] op);
    case (op)
      OP_RTYPE: return DEC_RTYPE;
      OP_ADDI:  return DEC_ADDI;
      OP_LW:    return DEC_LW;
      OP_SW:    return DEC_SW;
      OP_BEQ:   return DEC_BEQ;
      default:  return DEC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if -- decode <-> hazard scoreboard signals.
//   master (core decode): drives issue_*, src*, flush; reads stall, issued,
//                         fwd_sel1/2, busy, stall_cnt.
//   slave  (scoreboard) : the reverse.
interface hazard_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int LAT   = 3,
  parameter int CNT_W = 16
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(LAT + 1);

  logic             issue_valid;
  logic             issue_wr;
  logic             issue_ld;
  logic [RW-1:0]    issue_dst;
  logic             src1_en;
  logic             src2_en;
  logic [RW-1:0]    src1;
  logic [RW-1:0]    src2;
  logic             flush;
  logic             stall;
  logic             issued;
  logic [SW-1:0]    fwd_sel1;
  logic [SW-1:0]    fwd_sel2;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output issue_valid, issue_wr, issue_ld, issue_dst,
    output src1_en, src2_en, src1, src2, flush,
    input  stall, issued, fwd_sel1, fwd_sel2, busy, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_wr, issue_ld, issue_dst,
    input  src1_en, src2_en, src1, src2, flush,
    output stall, issued, fwd_sel1, fwd_sel2, busy, stall_cnt
  );
endinterface

// File: rtl/sb_match.sv
// sb_match -- priority compare of one source operand against all tracked
// stages. Reports whether any valid entry writes the operand, the youngest
// (lowest-numbered) matching stage, and whether that entry is a load.
//   en, src : operand read enable and register number
//   ents    : tracked entries, index 1 = E ... LAT = W
//   hit, stage, is_ld : youngest-match result (stage=0 when no hit)
module sb_match
  import pipe_pkg::*;
#(
  parameter int LAT = 3,
  parameter int RW  = 5,
  parameter int SW  = 2
) (
  input  logic             en,
  input  logic [RW-1:0]    src,
  input  entry_t [LAT:1]   ents,
  output logic             hit,
  output logic [SW-1:0]    stage,
  output logic             is_ld
);

  logic [LAT:1] match;

  genvar gi;
  generate
    for (gi = 1; gi <= LAT; gi++) begin : g_cmp
      // Register zero is hard-wired, so it never creates a dependency.
      assign match[gi] = en && (src != '0) && ents[gi].valid &&
                         (ents[gi].dst == MAX_RW'(src));
    end
  endgenerate

  // Walk oldest to youngest so the youngest match overwrites the result.
  always_comb begin
    hit   = 1'b0;
    stage = '0;
    is_ld = 1'b0;
    for (int k = LAT; k >= 1; k--) begin
      if (match[k]) begin
        hit   = 1'b1;
        stage = SW'(k);
        is_ld = ents[k].ld;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- in-flight destination tracker and stall/bypass
// decision for the in-order MIPS pipeline.
//   clk, rst : clock and synchronous active-high reset
//   sb       : hazard_scoreboard_if.slave (issue request, operands, flush in;
//              stall, issued, fwd_sel1/2 combinational out; busy, stall_cnt
//              registered out)
// Build option: define HAZARD_SCOREBOARD_FWD_EN for forwarding mode (stall
// only on load-use, fwd_sel active). Undefined: stall on any in-flight match
// and fwd_sel tied to the register file.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREGS        = 32,
  parameter int LAT          = 3,
  parameter int FLUSH_STAGES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_scoreboard_if.slave   sb
);

  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(LAT + 1);

  entry_t [LAT:1]   ent_reg;
  entry_t [LAT:1]   ent_next;
  entry_t [LAT-1:1] kept;        // entries surviving flush that shift onward
  logic   [LAT:1]   valid_next;
  logic             busy_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             hit1, hit2, ld1, ld2;
  logic [SW-1:0]    stage1, stage2;

  sb_match #(.LAT(LAT), .RW(RW), .SW(SW)) u_match1 (
    .en(sb.src1_en), .src(sb.src1), .ents(ent_reg),
    .hit(hit1), .stage(stage1), .is_ld(ld1)
  );

  sb_match #(.LAT(LAT), .RW(RW), .SW(SW)) u_match2 (
    .en(sb.src2_en), .src(sb.src2), .ents(ent_reg),
    .hit(hit2), .stage(stage2), .is_ld(ld2)
  );

`ifdef HAZARD_SCOREBOARD_FWD_EN
  // Load data appears at stage 2, so only a load sitting in E cannot be
  // bypassed; everything else is forwarded from its youngest stage.
  logic load_use;
  assign load_use    = (hit1 && (stage1 == SW'(1)) && ld1) ||
                       (hit2 && (stage2 == SW'(1)) && ld2);
  assign sb.stall    = sb.issue_valid && load_use && !sb.flush;
  assign sb.fwd_sel1 = hit1 ? stage1 : SW'(FWD_REGFILE);
  assign sb.fwd_sel2 = hit2 ? stage2 : SW'(FWD_REGFILE);
`else
  logic unused_match;
  assign unused_match = ^{ld1, ld2, stage1, stage2};
  assign sb.stall     = sb.issue_valid && (hit1 || hit2) && !sb.flush;
  assign sb.fwd_sel1  = SW'(FWD_REGFILE);
  assign sb.fwd_sel2  = SW'(FWD_REGFILE);
`endif

  assign sb.issued    = sb.issue_valid && !sb.stall && !sb.flush;
  assign sb.busy      = busy_reg;
  assign sb.stall_cnt = cnt_reg;

  genvar gi;
  generate
    for (gi = 1; gi <= LAT; gi++) begin : g_shift
      if (gi < LAT) begin : g_keep
        // Flush kills the youngest stages before they shift.
        assign kept[gi] = (sb.flush && (gi <= FLUSH_STAGES)) ? '0 : ent_reg[gi];
      end
      if (gi == 1) begin : g_head
        // Writes to register zero are never tracked.
        assign ent_next[gi] = '{valid: sb.issued && sb.issue_wr && (sb.issue_dst != '0),
                                ld:    sb.issue_ld,
                                dst:   MAX_RW'(sb.issue_dst)};
      end else begin : g_body
        assign ent_next[gi] = kept[gi-1];
      end
      assign valid_next[gi] = ent_next[gi].valid;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_reg  <= '0;
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      ent_reg  <= ent_next;
      busy_reg <= |valid_next;
      if (sb.stall && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard -- directed scenarios plus randomized traffic checked
// against a queue-based model of in-flight writes (each tracked by its age
// in cycles since issue).
module tb_hazard_scoreboard;

  localparam int NREGS = 32;
  localparam int LAT   = 3;
  localparam int FS    = 1;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREGS(NREGS), .LAT(LAT), .CNT_W(CNT_W)) sb_if ();

  hazard_scoreboard #(.NREGS(NREGS), .LAT(LAT), .FLUSH_STAGES(FS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sb(sb_if)
  );

  typedef struct {
    int dst;
    bit ld;
    int age;
  } flight_t;

  flight_t q[$];
  int m_cnt = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Youngest in-flight write to src (age 0 = none).
  function automatic void find(input bit en, input int src, output int age, output bit ld);
    age = 0;
    ld  = 1'b0;
    if (en && src != 0) begin
      foreach (q[i]) begin
        if (q[i].dst == src && (age == 0 || q[i].age < age)) begin
          age = q[i].age;
          ld  = q[i].ld;
        end
      end
    end
  endfunction

  function automatic void model_eval(output bit st, output bit iss, output int f1, output int f2);
    int a1, a2;
    bit l1, l2;
    find(sb_if.src1_en, int'(sb_if.src1), a1, l1);
    find(sb_if.src2_en, int'(sb_if.src2), a2, l2);
`ifdef HAZARD_SCOREBOARD_FWD_EN
    st = sb_if.issue_valid && ((a1 == 1 && l1) || (a2 == 1 && l2));
    f1 = a1;
    f2 = a2;
`else
    st = sb_if.issue_valid && (a1 != 0 || a2 != 0);
    f1 = 0;
    f2 = 0;
`endif
    if (sb_if.flush) st = 1'b0;
    iss = sb_if.issue_valid && !st && !sb_if.flush;
  endfunction

  task automatic drive(input bit v, input bit wr, input bit ld, input int dst,
                       input bit e1, input int s1, input bit e2, input int s2, input bit fl);
    sb_if.issue_valid = v;
    sb_if.issue_wr    = wr;
    sb_if.issue_ld    = ld;
    sb_if.issue_dst   = 5'(dst);
    sb_if.src1_en     = e1;
    sb_if.src1        = 5'(s1);
    sb_if.src2_en     = e2;
    sb_if.src2        = 5'(s2);
    sb_if.flush       = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock, updating the model with the inputs held across the edge.
  task automatic tick();
    bit st, iss;
    int f1, f2;
    flight_t nq[$];
    model_eval(st, iss, f1, f2);
    $display("cyc %0d rst=%0b v=%0b wr=%0b ld=%0b dst=%0d s1=%0b/%0d s2=%0b/%0d fl=%0b -> stall=%0b issued=%0b fwd=%0d/%0d busy=%0b cnt=%0d",
             cyc, rst, sb_if.issue_valid, sb_if.issue_wr, sb_if.issue_ld, sb_if.issue_dst,
             sb_if.src1_en, sb_if.src1, sb_if.src2_en, sb_if.src2, sb_if.flush,
             sb_if.stall, sb_if.issued, sb_if.fwd_sel1, sb_if.fwd_sel2, sb_if.busy, sb_if.stall_cnt);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (st && m_cnt < CMAX) m_cnt++;
      foreach (q[i]) begin
        if (!(sb_if.flush && q[i].age <= FS) && q[i].age + 1 <= LAT)
          nq.push_back('{dst: q[i].dst, ld: q[i].ld, age: q[i].age + 1});
      end
      if (iss && sb_if.issue_wr && sb_if.issue_dst != 0)
        nq.push_back('{dst: int'(sb_if.issue_dst), ld: sb_if.issue_ld, age: 1});
      q = nq;
    end
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (LAT + 1) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 0, 3, 1, 3, 0, 0, 0);
    repeat (2) begin
      tick();
      @(negedge clk);
      checks++;
      if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", sb_if.stall); end
      checks++;
      if (sb_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", sb_if.busy); end
      checks++;
      if (sb_if.stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", sb_if.stall_cnt); end
    end
    rst = 1'b0;
    idle();
    tick();
    @(negedge clk);
    checks++;
    if (sb_if.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %0b want 0", sb_if.busy); end
  endtask

  task automatic test_raw();
    int cnt0;
    cnt0 = int'(sb_if.stall_cnt);
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0);          // add $3
    @(negedge clk);
    checks++;
    if (sb_if.issued !== 1'b1) begin errors++; $display("FAIL raw_producer_issued got %0b want 1", sb_if.issued); end
    tick();
`ifdef HAZARD_SCOREBOARD_FWD_EN
    drive(1, 0, 0, 0, 0, 0, 1, 3, 0);          // consumer reads $3 as rt
    @(negedge clk);
    checks++;
    if (sb_if.stall !== 1'b0 || sb_if.fwd_sel2 !== 2'd1) begin
      errors++; $display("FAIL raw_fwd1 got stall=%0b sel=%0d want stall=0 sel=1", sb_if.stall, sb_if.fwd_sel2);
    end
    tick();
    @(negedge clk);
    checks++;
    if (sb_if.stall !== 1'b0 || sb_if.fwd_sel2 !== 2'd2) begin
      errors++; $display("FAIL raw_fwd2 got stall=%0b sel=%0d want stall=0 sel=2", sb_if.stall, sb_if.fwd_sel2);
    end
    tick();
    drain();
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0);          // lw $5
    tick();
    drive(1, 0, 0, 0, 1, 5, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %0b want 1", sb_if.stall); end
    tick();
    @(negedge clk);
    checks++;
    if (sb_if.stall !== 1'b0 || sb_if.fwd_sel1 !== 2'd2) begin
      errors++; $display("FAIL loaduse_fwd got stall=%0b sel=%0d want stall=0 sel=2", sb_if.stall, sb_if.fwd_sel1);
    end
    checks++;
    if (int'(sb_if.stall_cnt) !== cnt0 + 1) begin
      errors++; $display("FAIL loaduse_cnt got %0d want %0d", sb_if.stall_cnt, cnt0 + 1);
    end
    tick();
`else
    drive(1, 1, 0, 7, 1, 3, 0, 0, 0);          // consumer reads $3 as rs
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      checks++;
      if (sb_if.stall !== 1'b1 || sb_if.issued !== 1'b0) begin
        errors++; $display("FAIL raw_stall[%0d] got stall=%0b issued=%0b want 1/0", i, sb_if.stall, sb_if.issued);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (sb_if.stall !== 1'b0 || sb_if.issued !== 1'b1) begin
      errors++; $display("FAIL raw_release got stall=%0b issued=%0b want 0/1", sb_if.stall, sb_if.issued);
    end
    checks++;
    if (int'(sb_if.stall_cnt) !== cnt0 + 3) begin
      errors++; $display("FAIL raw_cnt got %0d want %0d", sb_if.stall_cnt, cnt0 + 3);
    end
    checks++;
    if (sb_if.fwd_sel1 !== 2'd0) begin errors++; $display("FAIL raw_nofwd_sel got %0d want 0", sb_if.fwd_sel1); end
    tick();
`endif
    drain();
  endtask

  task automatic test_zero_priority();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);          // write to $0
    tick();
    drive(1, 0, 0, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (sb_if.stall !== 1'b0 || sb_if.fwd_sel1 !== 2'd0) begin
      errors++; $display("FAIL zero_reg got stall=%0b sel=%0d want 0/0", sb_if.stall, sb_if.fwd_sel1);
    end
    checks++;
    if (sb_if.busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %0b want 0", sb_if.busy); end
    tick();
    drive(1, 1, 0, 4, 0, 0, 0, 0, 0);
    tick();
    tick();                                     // second write to $4
    drive(1, 0, 0, 0, 1, 4, 1, 4, 0);
    @(negedge clk);
`ifdef HAZARD_SCOREBOARD_FWD_EN
    checks++;
    if (sb_if.fwd_sel1 !== 2'd1 || sb_if.fwd_sel2 !== 2'd1) begin
      errors++; $display("FAIL priority got sel=%0d/%0d want 1/1", sb_if.fwd_sel1, sb_if.fwd_sel2);
    end
`else
    checks++;
    if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL priority_stall got %0b want 1", sb_if.stall); end
`endif
    drain();
  endtask

  task automatic test_flush();
    int cnt0;
    drive(1, 1, 0, 6, 0, 0, 0, 0, 0);
    tick();
    cnt0 = int'(sb_if.stall_cnt);
    drive(1, 1, 0, 9, 1, 6, 0, 0, 1);          // flush together with a dependent issue
    @(negedge clk);
    checks++;
    if (sb_if.issued !== 1'b0 || sb_if.stall !== 1'b0) begin
      errors++; $display("FAIL flush_out got issued=%0b stall=%0b want 0/0", sb_if.issued, sb_if.stall);
    end
    tick();
    drive(1, 0, 0, 0, 1, 6, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (sb_if.stall !== 1'b0 || sb_if.issued !== 1'b1) begin
      errors++; $display("FAIL flush_cleared got stall=%0b issued=%0b want 0/1", sb_if.stall, sb_if.issued);
    end
    checks++;
    if (int'(sb_if.stall_cnt) !== cnt0) begin
      errors++; $display("FAIL flush_cnt got %0d want %0d", sb_if.stall_cnt, cnt0);
    end
    checks++;
    if (sb_if.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", sb_if.busy); end
    tick();
    drain();
  endtask

  task automatic test_random();
    bit st, iss;
    int f1, f2;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7) == 0);
      @(negedge clk);
      model_eval(st, iss, f1, f2);
      checks++;
      if (sb_if.stall !== st) begin errors++; $display("FAIL rnd_stall cyc %0d got %0b want %0b", cyc, sb_if.stall, st); end
      checks++;
      if (sb_if.issued !== iss) begin errors++; $display("FAIL rnd_issued cyc %0d got %0b want %0b", cyc, sb_if.issued, iss); end
      checks++;
      if (int'(sb_if.fwd_sel1) !== f1 || int'(sb_if.fwd_sel2) !== f2) begin
        errors++; $display("FAIL rnd_fwd cyc %0d got %0d/%0d want %0d/%0d", cyc, sb_if.fwd_sel1, sb_if.fwd_sel2, f1, f2);
      end
      checks++;
      if (sb_if.busy !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %0b want %0b", cyc, sb_if.busy, q.size() != 0); end
      checks++;
      if (int'(sb_if.stall_cnt) !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", cyc, sb_if.stall_cnt, m_cnt); end
      tick();
    end
    rst = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 0, 2, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 3, 1, 2, 0, 0, 0);
    tick();
    rst = 1'b1;
    drive(1, 1, 0, 5, 1, 3, 1, 2, 0);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if (sb_if.busy !== 1'b0 || sb_if.stall_cnt !== '0) begin
      errors++; $display("FAIL reset_mid got busy=%0b cnt=%0d want 0/0", sb_if.busy, sb_if.stall_cnt);
    end
    drive(1, 0, 0, 0, 1, 5, 1, 2, 0);
    @(negedge clk);
    checks++;
    if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL reset_mid_stall got %0b want 0", sb_if.stall); end
    tick();
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw();
    test_zero_priority();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
